// File: rtl/fu_result_arbiter.sv
// Result-path arbiter: round-robin selection of one FU per cycle for the CDB
// broadcast and for the ROB write port, each path with its own pointer.
module fu_result_arbiter #(
   parameter int NFU = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [NFU-1:0]          cdb_req,
   input  logic [NFU-1:0][3:0]     cdb_req_id,
   input  logic [NFU-1:0][7:0]     cdb_req_val,
   output logic [NFU-1:0]          cdb_grant,
   output logic                    cdb_valid,
   output logic [3:0]              cdb_id,
   output logic [7:0]              cdb_val,
   input  logic [NFU-1:0]          rob_req,
   input  logic [NFU-1:0][3:0]     rob_req_robid,
   input  logic [NFU-1:0][7:0]     rob_req_flags,
   input  logic [NFU-1:0][7:0]     rob_req_wbs,
   input  logic [NFU-1:0][7:0]     rob_req_value,
   input  logic                    rob_ready,
   output logic [NFU-1:0]          rob_grant,
   output logic                    rob_valid,
   output logic [3:0]              rob_robid,
   output logic [7:0]              rob_flags,
   output logic [7:0]              rob_wbs,
   output logic [7:0]              rob_value
);

   localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

   // Handshake: an FU holds req and payload until its grant bit is seen high
   // in a cycle; that cycle is the transfer, and the result appears on the
   // registered outputs with a one-cycle valid strobe on the next edge.

   logic [PW-1:0] ptr_cdb;
   logic [PW-1:0] ptr_rob;
   logic [PW:0]   cdb_pick;
   logic [PW:0]   rob_pick;
   logic [PW-1:0] cdb_win;
   logic [PW-1:0] rob_win;
   logic          cdb_fire;
   logic          rob_fire;
   logic [PW-1:0] cdb_ptr_next;
   logic [PW-1:0] rob_ptr_next;

   // Returns {found, index}; scanning backwards lets the closest index to ptr win.
   function automatic logic [PW:0] rr_pick(input logic [NFU-1:0] req,
                                           input logic [PW-1:0]  ptr);
      logic [PW:0]   res;
      logic [PW-1:0] idx_p;
      int            idx;
      res = '0;
      for (int k = NFU - 1; k >= 0; k--) begin
         idx   = (int'(ptr) + k) % NFU;
         idx_p = PW'(idx);
         if (req[idx_p]) begin
            res = {1'b1, idx_p};
         end
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] win);
      return (win == PW'(NFU - 1)) ? '0 : win + 1'b1;
   endfunction

   always_comb begin
      cdb_pick     = rr_pick(cdb_req, ptr_cdb);
      rob_pick     = rr_pick(rob_req, ptr_rob);
      cdb_win      = cdb_pick[PW-1:0];
      rob_win      = rob_pick[PW-1:0];
      cdb_fire     = cdb_pick[PW] & ~flush & ~rst;
      rob_fire     = rob_pick[PW] & rob_ready & ~flush & ~rst;
      cdb_ptr_next = ptr_after(cdb_win);
      rob_ptr_next = ptr_after(rob_win);
   end

   always_comb begin
      cdb_grant = '0;
      rob_grant = '0;
      if (cdb_fire) begin
         cdb_grant[cdb_win] = 1'b1;
      end
      if (rob_fire) begin
         rob_grant[rob_win] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_cdb   <= '0;
         cdb_valid <= 1'b0;
         cdb_id    <= '0;
         cdb_val   <= '0;
      end else begin
         cdb_valid <= cdb_fire;
         if (cdb_fire) begin
            ptr_cdb <= cdb_ptr_next;
            cdb_id  <= cdb_req_id[cdb_win];
            cdb_val <= cdb_req_val[cdb_win];
         end
      end
   end

   // Payload registers hold between writes; only the strobe marks new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_rob   <= '0;
         rob_valid <= 1'b0;
         rob_robid <= '0;
         rob_flags <= '0;
         rob_wbs   <= '0;
         rob_value <= '0;
      end else begin
         rob_valid <= rob_fire;
         if (rob_fire) begin
            ptr_rob   <= rob_ptr_next;
            rob_robid <= rob_req_robid[rob_win];
            rob_flags <= rob_req_flags[rob_win];
            rob_wbs   <= rob_req_wbs[rob_win];
            rob_value <= rob_req_value[rob_win];
         end
      end
   end

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Self-checking bench for fu_result_arbiter: reference model of both paths,
// expected registered outputs queued at grant time and compared one edge later.
module tb_fu_result_arbiter;

   localparam int NFU = 4;

   logic                clk;
   logic                rst;
   logic                flush;
   logic [NFU-1:0]      cdb_req;
   logic [NFU-1:0][3:0] cdb_req_id;
   logic [NFU-1:0][7:0] cdb_req_val;
   logic [NFU-1:0]      cdb_grant;
   logic                cdb_valid;
   logic [3:0]          cdb_id;
   logic [7:0]          cdb_val;
   logic [NFU-1:0]      rob_req;
   logic [NFU-1:0][3:0] rob_req_robid;
   logic [NFU-1:0][7:0] rob_req_flags;
   logic [NFU-1:0][7:0] rob_req_wbs;
   logic [NFU-1:0][7:0] rob_req_value;
   logic                rob_ready;
   logic [NFU-1:0]      rob_grant;
   logic                rob_valid;
   logic [3:0]          rob_robid;
   logic [7:0]          rob_flags;
   logic [7:0]          rob_wbs;
   logic [7:0]          rob_value;

   fu_result_arbiter #(.NFU(NFU)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .cdb_req       (cdb_req),
      .cdb_req_id    (cdb_req_id),
      .cdb_req_val   (cdb_req_val),
      .cdb_grant     (cdb_grant),
      .cdb_valid     (cdb_valid),
      .cdb_id        (cdb_id),
      .cdb_val       (cdb_val),
      .rob_req       (rob_req),
      .rob_req_robid (rob_req_robid),
      .rob_req_flags (rob_req_flags),
      .rob_req_wbs   (rob_req_wbs),
      .rob_req_value (rob_req_value),
      .rob_ready     (rob_ready),
      .rob_grant     (rob_grant),
      .rob_valid     (rob_valid),
      .rob_robid     (rob_robid),
      .rob_flags     (rob_flags),
      .rob_wbs       (rob_wbs),
      .rob_value     (rob_value)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [12:0] exp_cdb_q[$];   // {valid, id, val}
   logic [28:0] exp_rob_q[$];   // {valid, robid, flags, wbs, value}

   int          m_ptr_cdb;
   int          m_ptr_rob;
   logic [3:0]  m_cdb_id;
   logic [7:0]  m_cdb_val;
   logic [3:0]  m_rob_robid;
   logic [7:0]  m_rob_flags;
   logic [7:0]  m_rob_wbs;
   logic [7:0]  m_rob_value;
   logic [NFU-1:0] last_cdb_grant;
   logic [NFU-1:0] last_rob_grant;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr_cdb   = 0;
      m_ptr_rob   = 0;
      m_cdb_id    = '0;
      m_cdb_val   = '0;
      m_rob_robid = '0;
      m_rob_flags = '0;
      m_rob_wbs   = '0;
      m_rob_value = '0;
      exp_cdb_q.delete();
      exp_rob_q.delete();
   endtask

   // Winner = requester with the smallest forward distance from the pointer.
   function automatic int model_pick(input logic [NFU-1:0] req, input int ptr);
      int best;
      int best_d;
      int d;
      best   = -1;
      best_d = NFU;
      for (int i = 0; i < NFU; i++) begin
         if (req[i]) begin
            d = (i - ptr + NFU) % NFU;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   // ---------------- driver: one cycle ----------------
   // Called after inputs are set (between posedge+1 and negedge).
   task automatic step();
      int wc;
      int wr;
      logic [NFU-1:0] eg_c;
      logic [NFU-1:0] eg_r;
      logic [12:0] ec;
      logic [28:0] er;
      @(negedge clk);
      wc = flush ? -1 : model_pick(cdb_req, m_ptr_cdb);
      wr = (flush || !rob_ready) ? -1 : model_pick(rob_req, m_ptr_rob);
      eg_c = '0;
      eg_r = '0;
      if (wc >= 0) eg_c[wc] = 1'b1;
      if (wr >= 0) eg_r[wr] = 1'b1;
      check_eq("cdb_grant", 32'(cdb_grant), 32'(eg_c));
      check_eq("rob_grant", 32'(rob_grant), 32'(eg_r));
      last_cdb_grant = cdb_grant;
      last_rob_grant = rob_grant;
      if (wc >= 0) begin
         m_cdb_id  = cdb_req_id[wc];
         m_cdb_val = cdb_req_val[wc];
         m_ptr_cdb = (wc + 1) % NFU;
      end
      if (wr >= 0) begin
         m_rob_robid = rob_req_robid[wr];
         m_rob_flags = rob_req_flags[wr];
         m_rob_wbs   = rob_req_wbs[wr];
         m_rob_value = rob_req_value[wr];
         m_ptr_rob   = (wr + 1) % NFU;
      end
      exp_cdb_q.push_back({(wc >= 0), m_cdb_id, m_cdb_val});
      exp_rob_q.push_back({(wr >= 0), m_rob_robid, m_rob_flags, m_rob_wbs, m_rob_value});
      @(posedge clk);
      #1;
      if (exp_cdb_q.size() == 0 || exp_rob_q.size() == 0) begin
         check_eq("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         ec = exp_cdb_q.pop_front();
         er = exp_rob_q.pop_front();
         check_eq("cdb_valid", 32'(cdb_valid), 32'(ec[12]));
         check_eq("cdb_id",    32'(cdb_id),    32'(ec[11:8]));
         check_eq("cdb_val",   32'(cdb_val),   32'(ec[7:0]));
         check_eq("rob_valid", 32'(rob_valid), 32'(er[28]));
         check_eq("rob_robid", 32'(rob_robid), 32'(er[27:24]));
         check_eq("rob_flags", 32'(rob_flags), 32'(er[23:16]));
         check_eq("rob_wbs",   32'(rob_wbs),   32'(er[15:8]));
         check_eq("rob_value", 32'(rob_value), 32'(er[7:0]));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      rob_ready = 1'b1;
      cdb_req   = 4'b1111;
      rob_req   = 4'b1111;
      for (int i = 0; i < NFU; i++) begin
         cdb_req_id[i]    = 4'(i);
         cdb_req_val[i]   = 8'(8'h10 + i);
         rob_req_robid[i] = 4'(i + 8);
         rob_req_flags[i] = 8'(8'h20 + i);
         rob_req_wbs[i]   = 8'(8'h30 + i);
         rob_req_value[i] = 8'(8'h40 + i);
      end
      model_reset();

      // Reset held with all requests asserted
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cdb_grant", 32'(cdb_grant), 32'd0);
      check_eq("rst_rob_grant", 32'(rob_grant), 32'd0);
      check_eq("rst_cdb_valid", 32'(cdb_valid), 32'd0);
      check_eq("rst_cdb_id",    32'(cdb_id),    32'd0);
      check_eq("rst_cdb_val",   32'(cdb_val),   32'd0);
      check_eq("rst_rob_valid", 32'(rob_valid), 32'd0);
      check_eq("rst_rob_robid", 32'(rob_robid), 32'd0);
      check_eq("rst_rob_value", 32'(rob_value), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Round robin over all four FUs, eight cycles
      for (int k = 0; k < 8; k++) begin
         step();
         check_eq("rr_grant", 32'(last_cdb_grant), 32'(4'b0001 << (k % 4)));
         check_eq("rr_val",   32'(cdb_val),        32'(8'h10 + (k % 4)));
      end

      // Sparse requests with pointer wrap
      cdb_req = 4'b0100;
      step();
      check_eq("sparse_g2", 32'(last_cdb_grant), 32'h4);
      cdb_req = 4'b0101;
      step();
      check_eq("wrap_g0_a", 32'(last_cdb_grant), 32'h1);
      step();
      check_eq("wrap_g2",   32'(last_cdb_grant), 32'h4);
      step();
      check_eq("wrap_g0_b", 32'(last_cdb_grant), 32'h1);

      // ROB backpressure while the CDB keeps granting
      cdb_req          = 4'b1111;
      rob_req          = 4'b0010;
      rob_req_robid[1] = 4'h7;
      rob_ready        = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("bp_rob_grant", 32'(last_rob_grant), 32'd0);
         check_eq("bp_rob_valid", 32'(rob_valid),      32'd0);
         check_eq("bp_cdb_busy",  32'($countones(last_cdb_grant)), 32'd1);
      end
      rob_ready = 1'b1;
      step();
      check_eq("bp_rel_grant", 32'(last_rob_grant), 32'h2);
      check_eq("bp_rel_valid", 32'(rob_valid),      32'd1);
      check_eq("bp_rel_robid", 32'(rob_robid),      32'h7);

      // Flush kills both grants, then FU3 wins both paths together
      cdb_req = 4'b1000;
      rob_req = 4'b1000;
      flush   = 1'b1;
      step();
      check_eq("fl_cdb_grant", 32'(last_cdb_grant), 32'd0);
      check_eq("fl_rob_grant", 32'(last_rob_grant), 32'd0);
      check_eq("fl_cdb_valid", 32'(cdb_valid),      32'd0);
      check_eq("fl_rob_valid", 32'(rob_valid),      32'd0);
      flush = 1'b0;
      step();
      check_eq("post_fl_cdb", 32'(last_cdb_grant), 32'h8);
      check_eq("post_fl_rob", 32'(last_rob_grant), 32'h8);

      // Flush together with rob_ready low
      rob_ready = 1'b0;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      rob_ready = 1'b1;

      // Random traffic
      for (int k = 0; k < 80; k++) begin
         cdb_req   = 4'($urandom_range(0, 15));
         rob_req   = 4'($urandom_range(0, 15));
         rob_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < NFU; i++) begin
            cdb_req_id[i]    = 4'($urandom_range(0, 15));
            cdb_req_val[i]   = 8'($urandom_range(0, 255));
            rob_req_robid[i] = 4'($urandom_range(0, 15));
            rob_req_flags[i] = 8'($urandom_range(0, 255));
            rob_req_wbs[i]   = 8'($urandom_range(0, 255));
            rob_req_value[i] = 8'($urandom_range(0, 255));
         end
         step();
      end

      // Asynchronous reset while a broadcast strobe is high
      flush     = 1'b0;
      rob_ready = 1'b1;
      cdb_req   = 4'b0110;
      rob_req   = 4'b0000;
      step();
      check_eq("pre_arst_valid", 32'(cdb_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_cdb_valid", 32'(cdb_valid), 32'd0);
      check_eq("arst_cdb_grant", 32'(cdb_grant), 32'd0);
      check_eq("arst_cdb_val",   32'(cdb_val),   32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      cdb_req = 4'b1111;
      step();
      check_eq("post_arst_ptr", 32'(last_cdb_grant), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fu_result_arbiter.md
# fu_result_arbiter

Shares the two result paths, the common data bus (CDB) and the ROB write port, between NFU functional units such as the shift, ALU and load units. Each unit's output stage raises a request and holds its result until granted. The arbiter picks one winner per path per cycle using independent round-robin pointers. It then drives a registered broadcast to the CDB and a registered write to the ROB. It sits between the FU output stages and the CDB/ROB, and its grants feed each unit's `cdb_transmit` / `rob_transmit` inputs.

## Interface
- `NFU`, default 4: number of requesting functional units (2..8); pointer width is `$clog2(NFU)`.
- `clk  in  1`: system clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `flush  in  1`: synchronous pipeline flush; kills this cycle's grants and clears output valids.
- `cdb_req  in  NFU`: per-FU CDB request (FU `cdb_transmit_out`).
- `cdb_req_id  in  NFU x 4`: per-FU ROB tag for the CDB.
- `cdb_req_val  in  NFU x 8`: per-FU result value for the CDB.
- `cdb_grant  out  NFU`: one-hot CDB grant (to FU `cdb_transmit`); combinational.
- `cdb_valid  out  1`: registered CDB broadcast valid.
- `cdb_id  out  4`: registered broadcast tag.
- `cdb_val  out  8`: registered broadcast value.
- `rob_req  in  NFU`: per-FU ROB write request (FU `rob_transmit_out`).
- `rob_req_robid  in  NFU x 4`: per-FU ROB entry index.
- `rob_req_flags  in  NFU x 8`: per-FU flags.
- `rob_req_wbs  in  NFU x 8`: per-FU writeback select.
- `rob_req_value  in  NFU x 8`: per-FU result.
- `rob_ready  in  1`: ROB can accept a write on the next edge.
- `rob_grant  out  NFU`: one-hot ROB grant (to FU `rob_transmit`); combinational.
- `rob_valid  out  1`: registered ROB write strobe.
- `rob_robid`, `rob_flags`, `rob_wbs`, `rob_value`  out  4/8/8/8: registered ROB write payload.

## Operation
- Both paths have the same structure and run independently. Each path has a pointer `ptr` in 0..NFU-1.
- Winner: the first index i with req[i]=1, scanning `ptr, ptr+1, …` modulo NFU.
- CDB: if any `cdb_req` is set and `flush`=0, the winner's `cdb_grant` bit is 1.
  - On the next edge: `cdb_valid`<=1, and `cdb_id`/`cdb_val` <= the winner's inputs.
  - `ptr_cdb` <= (winner+1) mod NFU.
- ROB: the same, with `rob_ready` as an extra qualifier. If `rob_ready`=0, no grant is issued, `rob_valid`<=0, and `ptr_rob` is unchanged.
- No grant on a path: valid<=0, payload registers hold their last value, pointer holds.
- At most one grant bit per path per cycle. A CDB grant and a ROB grant may go to the same FU in the same cycle, or to different FUs.
- FUs must hold req and payload stable until granted. The arbiter does not buffer ungranted requests.
- `flush`=1: both grant vectors are 0, and both valids <=0 on the next edge. Pointers are unchanged.
- Requests and payloads for FU indices that lose arbitration are ignored.

## Timing
- Grants are combinational from req/ptr/`rob_ready`/`flush`, with no registers in that path.
- Broadcast/write latency is 1 cycle from grant. Valid outputs are single-cycle strobes per grant.
- Throughput is one result per path per cycle.
- Fairness: a continuously asserted request is granted within NFU cycles on the CDB. On the ROB it is granted within NFU `rob_ready`=1 cycles.
- Reset (asynchronous, while `rst`=1):
  - `cdb_valid`=0, `cdb_id`=0, `cdb_val`=0.
  - `rob_valid`=0, and all `rob_*` payload outputs are 0.
  - `ptr_cdb`=`ptr_rob`=0.
  - Grants are 0 while `rst` is high, regardless of req.
- Reset asserted mid-operation: the in-flight registered strobe is dropped, with no partial write.
- First cycle after reset release: the arbiter operates normally with pointers at 0.
- Pointer wrap: a winner at NFU-1 sets the pointer to 0.
- Simultaneous `flush` and `rob_ready`=0: flush takes priority. The visible result is identical: no grant.

## Test plan
- Reset: hold `rst`=1 with all `cdb_req`=4'b1111 → `cdb_grant`=0, `rob_grant`=0, all outputs 0. Release → same cycle `cdb_grant`=4'b0001; next cycle `cdb_valid`=1, `cdb_id`/`cdb_val` equal FU0's values.
- Round-robin, NFU=4: `cdb_req`=4'b1111 held for 8 cycles, FU i with id=i and val=8'h10+i → grant order 0,1,2,3,0,1,2,3. `cdb_val` sequence is 10,11,12,13,10,11,12,13, each 1 cycle after its grant.
- Sparse and wrap: `ptr_cdb`=3 (after granting FU2), `cdb_req`=4'b0101 → grant FU0, then FU2, then FU0; the pointer wraps 3→1→3→1.
- ROB backpressure: `rob_req`=4'b0010 with robid=4'h7, `rob_ready`=0 for 3 cycles → `rob_grant`=0 and `rob_valid`=0. Raise `rob_ready` → `rob_grant`=4'b0010; next cycle `rob_valid`=1, `rob_robid`=7. Meanwhile the CDB path keeps granting normally.
- Flush: `cdb_req`=4'b1000 and `rob_req`=4'b1000 with `flush`=1 → both grants 0 and valids 0 the next cycle. With `flush` low the next cycle → FU3 is granted on both paths in the same cycle.
- Async reset mid-stream: assert `rst` between clock edges while `cdb_valid`=1 → `cdb_valid` drops to 0 immediately, without waiting for a clock edge, and the pointer returns to 0.
